// File: rtl/comparator_pkg.sv
// Shared types and constants for the registered magnitude comparator.
// Build option: define COMPARATOR_SIGNED_EN for two's-complement comparison.
package comparator_pkg;

    localparam int unsigned CMP_WIDTH_DEFAULT = 20;

    typedef enum logic [1:0] {
        CMP_EQ   = 2'd0,
        CMP_A_GT = 2'd1,
        CMP_B_GT = 2'd2
    } cmp_result_t;

    // Decode a result into {same, a_high, b_high}; exactly one bit set for legal codes.
    function automatic logic [2:0] cmp_onehot(input cmp_result_t r);
        logic [2:0] f;
        case (r)
            CMP_EQ:   f = 3'b100;
            CMP_A_GT: f = 3'b010;
            CMP_B_GT: f = 3'b001;
            default:  f = 3'b100;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/mag_compare.sv
// Combinational comparator: ordering of a vs b plus |a-b|.
// Build option: COMPARATOR_SIGNED_EN selects signed operands (default unsigned).
module mag_compare
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = CMP_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_result_t      result,
    output logic [WIDTH-1:0] diff
);

    // One extra bit holds the full difference range, so its top bit is the "a < b" sign.
    logic [WIDTH:0] a_x;
    logic [WIDTH:0] b_x;
    logic [WIDTH:0] sub;

`ifdef COMPARATOR_SIGNED_EN
    assign a_x = {a[WIDTH-1], a};
    assign b_x = {b[WIDTH-1], b};
`else
    assign a_x = {1'b0, a};
    assign b_x = {1'b0, b};
`endif

    assign sub = a_x - b_x;

    // Classify from the extended difference and fold a negative result to its magnitude.
    always_comb begin
        result = CMP_A_GT;
        diff   = sub[WIDTH-1:0];
        if (sub == '0) begin
            result = CMP_EQ;
        end else if (sub[WIDTH]) begin
            result = CMP_B_GT;
            diff   = -sub[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/comparator_always.sv
// Registered comparator: one-cycle latency, results hold while in_valid is low.
// Build option: COMPARATOR_SIGNED_EN (signed compare); default build is unsigned.
module comparator_always
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = CMP_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             Same,
    output logic             A_High,
    output logic             B_High,
    output logic [WIDTH-1:0] Diff
);

    cmp_result_t      res_c;
    logic [WIDTH-1:0] diff_c;

    logic             same_d;
    logic             a_high_d;
    logic             b_high_d;
    logic [WIDTH-1:0] diff_d;

    mag_compare #(.WIDTH(WIDTH)) u_mag (
        .a      (A),
        .b      (B),
        .result (res_c),
        .diff   (diff_c)
    );

    // Next result: load on in_valid, otherwise keep the current registers.
    always_comb begin
        same_d   = Same;
        a_high_d = A_High;
        b_high_d = B_High;
        diff_d   = Diff;
        if (in_valid) begin
            {same_d, a_high_d, b_high_d} = cmp_onehot(res_c);
            diff_d = diff_c;
        end
    end

    // Result and valid registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Same      <= 1'b0;
            A_High    <= 1'b0;
            B_High    <= 1'b0;
            Diff      <= '0;
        end else begin
            out_valid <= in_valid;
            Same      <= same_d;
            A_High    <= a_high_d;
            B_High    <= b_high_d;
            Diff      <= diff_d;
        end
    end

endmodule

// File: tb/tb_comparator_always.sv
// Scoreboard bench for comparator_always: driver queues expected results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_comparator_always;

    localparam int unsigned W = 20;
    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

    typedef struct packed {
        logic         same;
        logic         a_high;
        logic         b_high;
        logic [W-1:0] diff;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         Same;
    logic         A_High;
    logic         B_High;
    logic [W-1:0] Diff;

    int   n_checks = 0;
    int   n_pass   = 0;
    res_t exp_q[$];
    res_t held;
    logic exp_vld;

    comparator_always #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .Same      (Same),
        .A_High    (A_High),
        .B_High    (B_High),
        .Diff      (Diff)
    );

    always #5 clk = ~clk;

    // Reference: interpret operands as integers and apply the ordering rules directly.
    function automatic res_t ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
        longint va, vb, d;
        res_t   r;
`ifdef COMPARATOR_SIGNED_EN
        va = longint'($signed(a));
        vb = longint'($signed(b));
`else
        va = longint'(a);
        vb = longint'(b);
`endif
        r.same   = (va == vb);
        r.a_high = (va > vb);
        r.b_high = (vb > va);
        d        = (va > vb) ? (va - vb) : (vb - va);
        r.diff   = W'(d);
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r.same   = Same;
        r.a_high = A_High;
        r.b_high = B_High;
        r.diff   = Diff;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Expected out_valid is the previous edge's in_valid, cleared by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_vld <= 1'b0;
        else        exp_vld <= in_valid;
    end

    // Monitor: compare valid, pop on out_valid, otherwise require held values.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", 64'({out_valid, dut_res()}), 64'(0));
            held = '0;
        end else begin
            check("out_valid", 64'(out_valid), 64'(exp_vld));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(1), 64'(0));
                end else begin
                    held = exp_q.pop_front();
                    check("result", 64'(dut_res()), 64'(held));
                end
            end else begin
                check("hold", 64'(dut_res()), 64'(held));
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        in_valid = v;
        A        = a;
        B        = b;
        if (v) exp_q.push_back(ref_cmp(a, b));
    endtask

    // Assert reset between edges with a result in flight; outputs must clear at once.
    task automatic reset_mid_stream(input logic [W-1:0] a, input logic [W-1:0] b);
        drive(1'b1, a, b);
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset", 64'({out_valid, dut_res()}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        held     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                drive(1'b1, W'(i), W'(j));

        drive(1'b1, ONES, '0);
        drive(1'b1, W'(20'h807FF), W'(20'hFFFD8));
        drive(1'b1, ONES, ONES);
        drive(1'b1, '0, '0);
        drive(1'b1, W'(20'hFCFFF), W'(20'h0F800));
        drive(1'b1, MSB, '0);
        drive(1'b1, MSB, ONES);
        drive(1'b1, '0, MSB);

        repeat (3) drive(1'b0, W'($urandom), W'($urandom));
        reset_mid_stream(W'(20'h12345), W'(20'h00001));
        drive(1'b0, '0, '0);
        drive(1'b1, W'(20'h00007), W'(20'h00009));

        for (int k = 0; k < 300; k++) begin
            logic [W-1:0] ra, rb;
            int unsigned  sel;
            sel = $urandom_range(0, 7);
            ra  = W'($urandom);
            rb  = W'($urandom);
            if (sel == 0) rb = ra;
            if (sel == 1) ra = ONES;
            if (sel == 2) rb = MSB;
            if (sel == 3) ra = '0;
            drive(($urandom_range(0, 3) != 0), ra, rb);
        end

        drive(1'b0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
